// File: rtl/rf_pkg.sv
// Shared register-file constants and the dump reader state encoding.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_LOAD,
    DR_SEND,
    DR_DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one combinational read port and streams each
// (index, value) pair out on a valid/ready interface. Never writes the register file.
module regfile_dump_reader
  import rf_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data
);

  // x0 is hardwired to zero, so a SKIP_ZERO dump begins at index 1
  localparam logic [ADDR_W-1:0] FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  dump_state_t       state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;
  logic              handshake;

  assign idx_inc   = idx + ADDR_W'(1);
  assign handshake = (state == DR_SEND) && out_ready;

  // State register; abort is folded into the next-state logic
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: abort overrides everything, start only matters in IDLE
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = DR_IDLE;
    end else begin
      case (state)
        DR_IDLE: if (start) state_next = DR_LOAD;
        DR_LOAD: state_next = DR_SEND;
        DR_SEND: if (handshake && (idx == LAST)) state_next = DR_DONE;
        DR_DONE: state_next = DR_IDLE;
        default: state_next = DR_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; in SEND the read port looks one register ahead
  // so the next word is ready to capture on the handshake edge
  always_comb begin
    busy      = (state != DR_IDLE);
    done      = (state == DR_DONE);
    out_valid = (state == DR_SEND);
    rd_addr   = (state == DR_SEND) ? idx_inc : idx;
  end

  // Walk index and captured word; the word is held until the sink accepts it
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_index <= '0;
      out_data  <= '0;
    end else if (!abort) begin
      case (state)
        DR_IDLE: begin
          if (start) idx <= FIRST;
        end
        DR_LOAD: begin
          out_data  <= rd_data;
          out_index <= idx;
        end
        DR_SEND: begin
          if (handshake && (idx != LAST)) begin
            idx       <= idx_inc;
            out_data  <= rd_data;
            out_index <= idx_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
